// File: rtl/axi_write_master_pkg.sv
// Shared types and constants for the single-outstanding AXI3 write master.
// Optional alignment check macro: AXI_WR_MASTER_ALIGN_CHECK_EN.
package axi_write_master_pkg;

    localparam int unsigned MAX_SIZE = 2;
    localparam int unsigned ID_W     = 4;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = 4;
    localparam int unsigned LEN_W    = 4;
    localparam int unsigned SIZE_W   = 3;
    localparam int unsigned BURST_W  = 2;
    localparam int unsigned RESP_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [RESP_W-1:0] OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] DECERR = 2'b11;

    localparam logic [BURST_W-1:0] FIXED = 2'b00;
    localparam logic [BURST_W-1:0] INCR  = 2'b01;
    localparam logic [BURST_W-1:0] WRAP  = 2'b10;

    // Latched burst command, also the source of the AW channel fields.
    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } cmd_t;

    // A command is legal when its size fits the bus and its address is size-aligned.
    function automatic logic cmd_is_legal(input logic [ADDR_W-1:0] addr,
                                          input logic [SIZE_W-1:0] size);
        logic [ADDR_W-1:0] mask;
        mask = (ADDR_W'(1) << size) - ADDR_W'(1);
        return (32'(size) <= MAX_SIZE) && ((addr & mask) == '0);
    endfunction

endpackage

// File: rtl/axi_wr_beat_counter.sv
// Counts accepted W beats of the current burst and flags the last one.
import axi_write_master_pkg::*;

module axi_wr_beat_counter (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_beat,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_last,
    output logic             o_done
);

    logic [LEN_W-1:0] r_cnt;
    logic             r_done;

    // Counter parks at i_len once the last beat is taken, so it never wraps.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_beat) begin
            if (r_cnt == i_len) begin
                r_done <= 1'b1;
            end else begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
        end
    end

    assign o_last = (r_cnt == i_len);
    assign o_done = r_done;

endmodule

// File: rtl/axi_write_master.sv
// Single-outstanding AXI3 write master: one AW, a stream of W beats, one B, then a done record.
// Define AXI_WR_MASTER_ALIGN_CHECK_EN to reject oversized or misaligned commands with SLVERR.
import axi_write_master_pkg::*;

module axi_write_master (
    input  logic               a_clk,
    input  logic               a_reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ID_W-1:0]    cmd_id,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [SIZE_W-1:0]  cmd_size,
    input  logic [BURST_W-1:0] cmd_burst,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic [DATA_W-1:0]  src_data,
    input  logic [STRB_W-1:0]  src_strb,
    output logic [ID_W-1:0]    aw_id,
    output logic [ADDR_W-1:0]  aw_addr,
    output logic [LEN_W-1:0]   aw_len,
    output logic [SIZE_W-1:0]  aw_size,
    output logic [BURST_W-1:0] aw_burst,
    output logic               aw_valid,
    input  logic               aw_ready,
    output logic [ID_W-1:0]    w_id,
    output logic [DATA_W-1:0]  w_data,
    output logic [STRB_W-1:0]  w_strb,
    output logic               w_last,
    output logic               w_valid,
    input  logic               w_ready,
    input  logic [ID_W-1:0]    b_id,
    input  logic [RESP_W-1:0]  b_resp,
    input  logic               b_valid,
    output logic               b_ready,
    output logic               done_valid,
    input  logic               done_ready,
    output logic [ID_W-1:0]    done_id,
    output logic [RESP_W-1:0]  done_resp
);

    state_t              r_state;
    cmd_t                r_cmd;
    logic                r_aw_pend;
    logic [RESP_W-1:0]   r_done_resp;

    cmd_t                w_cmd_in;
    logic                w_in_burst;
    logic                w_accept;
    logic                w_beat_open;
    logic                w_beat_fire;
    logic                w_aw_fire;
    logic                w_last_beat;
    logic                w_beats_done;

    assign w_cmd_in = '{id: cmd_id, addr: cmd_addr, len: cmd_len,
                        size: cmd_size, burst: cmd_burst};

    // Ready is held low while reset is asserted so nothing is accepted in the reset cycle.
    assign cmd_ready   = (r_state == IDLE) && !a_reset;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_in_burst  = (r_state == BURST);
    assign w_beat_open = w_in_burst && !w_beats_done;
    assign w_aw_fire   = r_aw_pend && aw_ready;
    assign w_beat_fire = w_valid && w_ready;

    // W channel is a gated pass-through of the source stream during the burst.
    assign w_valid   = w_beat_open && src_valid;
    assign src_ready = w_beat_open && w_ready;
    assign w_data    = w_in_burst ? src_data : '0;
    assign w_strb    = w_in_burst ? src_strb : '0;
    assign w_last    = w_in_burst && w_last_beat;
    assign w_id      = r_cmd.id;

    assign aw_valid  = r_aw_pend;
    assign aw_id     = r_cmd.id;
    assign aw_addr   = r_cmd.addr;
    assign aw_len    = r_cmd.len;
    assign aw_size   = r_cmd.size;
    assign aw_burst  = r_cmd.burst;

    assign b_ready    = (r_state == RESP);
    assign done_valid = (r_state == DONE);
    assign done_id    = r_cmd.id;
    assign done_resp  = r_done_resp;

    axi_wr_beat_counter u_beat_counter (
        .i_clk   (a_clk),
        .i_reset (a_reset),
        .i_clear (w_accept),
        .i_beat  (w_beat_fire),
        .i_len   (r_cmd.len),
        .o_last  (w_last_beat),
        .o_done  (w_beats_done)
    );

    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_aw_pend   <= 1'b0;
            r_done_resp <= OKAY;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cmd       <= w_cmd_in;
                        r_done_resp <= OKAY;
`ifdef AXI_WR_MASTER_ALIGN_CHECK_EN
                        if (!cmd_is_legal(cmd_addr, cmd_size)) begin
                            r_state     <= DONE;
                            r_done_resp <= SLVERR;
                        end else begin
                            r_state   <= BURST;
                            r_aw_pend <= 1'b1;
                        end
`else
                        r_state   <= BURST;
                        r_aw_pend <= 1'b1;
`endif
                    end
                end
                BURST: begin
                    if (w_aw_fire) begin
                        r_aw_pend <= 1'b0;
                    end
                    // Leave once both the address and the final beat have handshaked.
                    if ((!r_aw_pend || w_aw_fire) &&
                        (w_beats_done || (w_beat_fire && w_last_beat))) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (b_valid) begin
                        r_done_resp <= (b_id != r_cmd.id) ? SLVERR : b_resp;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_master.sv
// Self-checking bench for axi_write_master: command table plus randomized handshakes vs a beat-level model.
module tb_axi_write_master;

`ifdef AXI_WR_MASTER_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        a_clk = 1'b0;
    logic        a_reset;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        src_valid, src_ready;
    logic [31:0] src_data;
    logic [3:0]  src_strb;
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic [3:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        aw_valid, aw_ready;
    logic [3:0]  w_id;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last, w_valid, w_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid, b_ready;
    logic        done_valid, done_ready;
    logic [3:0]  done_id;
    logic [1:0]  done_resp;

    int checks = 0;
    int failures = 0;

    always #5 a_clk = ~a_clk;

    axi_write_master dut (
        .a_clk(a_clk), .a_reset(a_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_strb(src_strb),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_id(w_id), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .done_valid(done_valid), .done_ready(done_ready), .done_id(done_id), .done_resp(done_resp)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  bid;
        logic [1:0]  bresp;
        int          mode;      // 0 all ready, 1 random, 2 w_ready every other cycle, 3 aw_ready late
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic bit model_bad(input logic [31:0] addr, input logic [2:0] size);
        return ALIGN_EN && ((size > 3'd2) || ((addr % (32'd1 << size)) != 32'd0));
    endfunction

    function automatic logic [1:0] model_resp(input vec_t v);
        if (model_bad(v.addr, v.size)) return 2'b10;
        if (v.bid != v.id) return 2'b10;
        return v.bresp;
    endfunction

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
        src_valid = 1'b0; src_data = '0; src_strb = '0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_id = '0; b_resp = '0; done_ready = 1'b0;
    endtask

    function automatic bit any_output();
        return |{cmd_ready, src_ready, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
                 w_id, w_data, w_strb, w_last, w_valid, b_ready, done_valid, done_id, done_resp};
    endfunction

    // One command end to end; the model tracks beats taken, AW seen, B seen.
    task automatic run_cmd(input vec_t v);
        logic [31:0] sdata[$];
        logic [3:0]  sstrb[$];
        int nbeats, k, done_cyc;
        bit bad, aw_seen, b_seen, fin, aw_now, b_now, k_inc, exp_open, exp_bready, exp_done;
        nbeats = int'(v.len) + 1;
        for (int i = 0; i <= nbeats; i++) begin
            sdata.push_back($urandom);
            sstrb.push_back(4'($urandom));
        end
        bad = model_bad(v.addr, v.size);
        aw_seen = 0; b_seen = 0; fin = 0; k = 0; done_cyc = -1;

        @(negedge a_clk);
        idle_inputs();
        cmd_valid = 1'b1; cmd_id = v.id; cmd_addr = v.addr; cmd_len = v.len;
        cmd_size = v.size; cmd_burst = v.burst;
        #1 check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        @(posedge a_clk);

        for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
            @(negedge a_clk);
            cmd_valid = 1'b0;
            cmd_id = 4'($urandom); cmd_addr = $urandom; cmd_len = 4'($urandom);
            cmd_size = 3'($urandom); cmd_burst = 2'($urandom);
            case (v.mode)
                1: begin
                    src_valid  = ($urandom_range(0, 3) != 0);
                    w_ready    = ($urandom_range(0, 3) != 0);
                    aw_ready   = ($urandom_range(0, 2) == 0);
                    b_valid    = ($urandom_range(0, 1) == 0);
                    done_ready = ($urandom_range(0, 1) == 0);
                end
                2: begin
                    src_valid = 1'b1; w_ready = ((cyc % 2) == 0); aw_ready = 1'b1;
                    b_valid = 1'b1; done_ready = 1'b1;
                end
                3: begin
                    src_valid = 1'b1; w_ready = 1'b1; aw_ready = (cyc > 6);
                    b_valid = 1'b1; done_ready = 1'b1;
                end
                default: begin
                    src_valid = 1'b1; w_ready = 1'b1; aw_ready = 1'b1;
                    b_valid = 1'b1; done_ready = 1'b1;
                end
            endcase
            src_data = sdata[k];
            src_strb = sstrb[k];
            b_id = v.bid;
            b_resp = v.bresp;
            #1;
            exp_open   = !bad && (k < nbeats);
            exp_bready = !bad && aw_seen && (k == nbeats) && !b_seen;
            exp_done   = bad || b_seen;
            check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
            check("aw_valid", 64'(aw_valid), 64'(!bad && !aw_seen));
            check("w_valid", 64'(w_valid), 64'(exp_open && src_valid));
            check("src_ready", 64'(src_ready), 64'(exp_open && w_ready));
            check("b_ready", 64'(b_ready), 64'(exp_bready));
            check("done_valid", 64'(done_valid), 64'(exp_done));
            aw_now = aw_valid && aw_ready;
            if (aw_now) begin
                check("aw_id", 64'(aw_id), 64'(v.id));
                check("aw_addr", 64'(aw_addr), 64'(v.addr));
                check("aw_len", 64'(aw_len), 64'(v.len));
                check("aw_size", 64'(aw_size), 64'(v.size));
                check("aw_burst", 64'(aw_burst), 64'(v.burst));
            end
            k_inc = 0;
            if (w_valid && w_ready) begin
                check("w_data", 64'(w_data), 64'(sdata[k]));
                check("w_strb", 64'(w_strb), 64'(sstrb[k]));
                check("w_id", 64'(w_id), 64'(v.id));
                check("w_last", 64'(w_last), 64'(k == nbeats - 1));
                k_inc = 1;
            end
            b_now = b_ready && b_valid;
            if (done_valid) begin
                check("done_id", 64'(done_id), 64'(v.id));
                check("done_resp", 64'(done_resp), 64'(v.exp_resp));
                if (done_cyc < 0) done_cyc = cyc;
                if (done_ready) fin = 1;
            end
            @(posedge a_clk);
            if (aw_now) aw_seen = 1;
            if (k_inc) k++;
            if (b_now) b_seen = 1;
        end
        if (!fin) check("cmd_timeout", 64'(0), 64'(1));
        check("beats_taken", 64'(k), bad ? 64'(0) : 64'(nbeats));
        if (v.mode == 0) check("done_latency", 64'(done_cyc), bad ? 64'(1) : 64'(nbeats + 2));
    endtask

    // Reset on the 2nd beat of an 8-beat burst must abort with no completion.
    task automatic reset_mid_burst();
        @(negedge a_clk);
        idle_inputs();
        cmd_valid = 1'b1; cmd_id = 4'd6; cmd_addr = 32'h300; cmd_len = 4'd7;
        cmd_size = 3'd2; cmd_burst = 2'b01;
        src_valid = 1'b1; src_data = 32'hA5A5_0001; src_strb = 4'hF;
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_id = 4'd6;
        @(posedge a_clk);
        @(negedge a_clk);
        cmd_valid = 1'b0;
        #1 check("rst_beat1", 64'(w_valid && w_ready), 64'(1));
        @(posedge a_clk);
        @(negedge a_clk);
        #1 check("rst_beat2", 64'(w_valid && w_ready), 64'(1));
        a_reset = 1'b1;
        @(posedge a_clk);
        @(negedge a_clk);
        #1 check("rst_outputs_zero", 64'(any_output()), 64'(0));
        a_reset = 1'b0;
        #1 check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        for (int i = 0; i < 8; i++) begin
            @(negedge a_clk);
            #1;
            check("rst_no_done", 64'(done_valid), 64'(0));
            check("rst_no_aw", 64'(aw_valid), 64'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        idle_inputs();
        a_reset = 1'b1;
        @(negedge a_clk);
        @(negedge a_clk);
        #1;
        check("reset_outputs_zero", 64'(any_output()), 64'(0));
        check("reset_cmd_ready", 64'(cmd_ready), 64'(0));
        a_reset = 1'b0;
        #1 check("post_reset_cmd_ready", 64'(cmd_ready), 64'(1));

        vecs.push_back('{4'd3, 32'h10,  4'd0,  3'd2, 2'b01, 4'd3, 2'b00, 0, 2'b00});
        vecs.push_back('{4'd1, 32'h100, 4'd3,  3'd2, 2'b01, 4'd1, 2'b00, 2, 2'b00});
        vecs.push_back('{4'd2, 32'h200, 4'd3,  3'd2, 2'b01, 4'd2, 2'b01, 3, 2'b01});
        vecs.push_back('{4'd3, 32'h40,  4'd0,  3'd2, 2'b01, 4'd5, 2'b00, 0, 2'b10});
        vecs.push_back('{4'd7, 32'h800, 4'd15, 3'd2, 2'b01, 4'd7, 2'b11, 1, 2'b11});
        vecs.push_back('{4'd4, 32'h2,   4'd1,  3'd2, 2'b01, 4'd4, 2'b00, 0,
                         ALIGN_EN ? 2'b10 : 2'b00});
        vecs.push_back('{4'd9, 32'h8,   4'd2,  3'd3, 2'b00, 4'd9, 2'b00, 0,
                         ALIGN_EN ? 2'b10 : 2'b00});
        vecs.push_back('{4'd8, 32'h20,  4'd5,  3'd1, 2'b10, 4'd8, 2'b00, 2, 2'b00});
        for (int i = 0; i < 14; i++) begin
            v.id    = 4'($urandom);
            v.addr  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            v.len   = 4'($urandom);
            v.size  = 3'($urandom_range(0, 2));
            v.burst = 2'($urandom_range(0, 2));
            v.bid   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : v.id;
            v.bresp = 2'($urandom);
            v.mode  = 1;
            v.exp_resp = model_resp(v);
            vecs.push_back(v);
        end

        foreach (vecs[i]) run_cmd(vecs[i]);

        reset_mid_burst();
        run_cmd('{4'd2, 32'h44, 4'd1, 3'd2, 2'b01, 4'd2, 2'b00, 0, 2'b00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
